// File: rtl/mode_counter_pkg.sv
// Shared definitions for the mode_counter block: FSM state encoding.
package mode_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mode_counter_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the reload (wrap) count.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mode_counter.sv
// Runtime-limit up/down counter with one-shot / auto-reload modes, start/stop control,
// pause on enable low, terminal tick and a saturating reload count.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH      = 11,
  parameter int WRAP_WIDTH = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  enable_i,
  input  logic                  dir_down_i,
  input  logic                  reload_i,
  input  logic [WIDTH-1:0]      limit_i,
  output logic [WIDTH-1:0]      count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tick_o,
  output logic [WRAP_WIDTH-1:0] wraps_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             down_q, down_d;
  logic             reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;
  logic             wrap_clear, wrap_inc;

  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] reload_val;
  logic             at_term;

  // Up runs 0 -> limit, down runs limit -> 0; reload returns to the start point.
  assign term_val   = down_q ? '0 : limit_q;
  assign reload_val = down_q ? limit_q : '0;
  assign at_term    = (count_q == term_val);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    down_d     = down_q;
    reload_d   = reload_q;
    busy_d     = busy_q;
    done_d     = done_q;
    tick_d     = 1'b0;
    wrap_clear = 1'b0;
    wrap_inc   = 1'b0;

    if (stop_i) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else if (start_i) begin
      limit_d    = limit_i;
      down_d     = dir_down_i;
      reload_d   = reload_i;
      count_d    = dir_down_i ? limit_i : '0;
      done_d     = 1'b0;
      busy_d     = 1'b1;
      state_d    = ST_RUN;
      wrap_clear = 1'b1;
    end else begin
      case (state_q)
        ST_RUN, ST_PAUSE: begin
          if (enable_i) begin
            if (at_term) begin
              tick_d = 1'b1;
              if (reload_q) begin
                count_d  = reload_val;
                wrap_inc = 1'b1;
                state_d  = ST_RUN;
              end else begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
              end
            end else begin
              count_d = down_q ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_PAUSE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      limit_q  <= '0;
      down_q   <= 1'b0;
      reload_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      down_q   <= down_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tick_q   <= tick_d;
    end
  end

  sat_counter #(
    .WIDTH(WRAP_WIDTH)
  ) u_wraps (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (wrap_clear),
    .inc_i   (wrap_inc),
    .count_o (wraps_o)
  );

  assign count_o = count_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign tick_o  = tick_q;

endmodule
